// File: rtl/reg_file_writeback_arbiter.sv
// Purpose: merges pipeline writeback and queued multi-cycle results onto the register file write port
// Latency: 1 cycle from arbitration (or from pop) to registered write; multi-cycle results take >=2 cycles (push, pop)
// Backpressure: out_mc_ready drops when the FIFO is full; the pipeline path is never stalled and always wins the port
//
// Ports:
//   clk, rst                     clock and synchronous active-high reset
//   in_pipe_valid/sel/data       single-cycle pipeline result, highest priority
//   in_mc_valid/sel/data         multi-cycle result offer, accepted when out_mc_ready
//   out_mc_ready                 FIFO has a free entry (from registered count only)
//   in_claim_en/sel              issue stage reserving a destination for a multi-cycle op
//   out_pending                  per-register "multi-cycle writeback outstanding" scoreboard
//   out_fifo_count               current FIFO occupancy
//   out_write_en/sel/data        registered register-file write port
module reg_file_writeback_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16,
  parameter int SEL_WIDTH  = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_pipe_valid,
  input  logic [SEL_WIDTH-1:0]  in_pipe_sel,
  input  logic [DATA_WIDTH-1:0] in_pipe_data,
  input  logic                  in_mc_valid,
  output logic                  out_mc_ready,
  input  logic [SEL_WIDTH-1:0]  in_mc_sel,
  input  logic [DATA_WIDTH-1:0] in_mc_data,
  input  logic                  in_claim_en,
  input  logic [SEL_WIDTH-1:0]  in_claim_sel,
  output logic [NUM_REGS-1:0]   out_pending,
  output logic [SEL_WIDTH-1:0]  out_fifo_count,
  output logic                  out_write_en,
  output logic [SEL_WIDTH-1:0]  out_write_sel,
  output logic [DATA_WIDTH-1:0] out_write_data
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [SEL_WIDTH-1:0] LP_DEPTH = SEL_WIDTH'(FIFO_DEPTH);

  // FIFO storage; contents need no reset because the pointers/count define validity
  logic [SEL_WIDTH-1:0]  r_fifo_sel  [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] r_fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [SEL_WIDTH-1:0]  r_count;
  logic [NUM_REGS-1:0]   r_pending;
  logic                  r_write_en;
  logic [SEL_WIDTH-1:0]  r_write_sel;
  logic [DATA_WIDTH-1:0] r_write_data;

  logic                  w_ready;
  logic                  w_push;
  logic                  w_pipe_win;
  logic                  w_pop;
  logic                  w_claim;
  logic [SEL_WIDTH-1:0]  w_head_sel;
  logic [DATA_WIDTH-1:0] w_head_data;
  logic [NUM_REGS-1:0]   w_pending_nxt;

  // Ready looks only at the registered count so it never depends on this cycle's pop.
  assign w_ready     = (r_count < LP_DEPTH);
  assign w_push      = in_mc_valid && w_ready;
  // A pipe result to r0 is a no-op and must not steal the port from the FIFO.
  assign w_pipe_win  = in_pipe_valid && (in_pipe_sel != '0);
  assign w_pop       = !w_pipe_win && (r_count != '0);
  assign w_claim     = in_claim_en && (in_claim_sel != '0);
  assign w_head_sel  = r_fifo_sel[r_rd_ptr];
  assign w_head_data = r_fifo_data[r_rd_ptr];

  // Clear from the pop is applied first so a same-cycle claim of that register survives:
  // the claim belongs to a newer op whose result is still outstanding.
  always_comb begin
    w_pending_nxt = r_pending;
    if (w_pop) begin
      w_pending_nxt[w_head_sel] = 1'b0;
    end
    if (w_claim) begin
      w_pending_nxt[in_claim_sel] = 1'b1;
    end
    w_pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_sel[r_wr_ptr]  <= in_mc_sel;
      r_fifo_data[r_wr_ptr] <= in_mc_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_pending    <= '0;
      r_write_en   <= 1'b0;
      r_write_sel  <= '0;
      r_write_data <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + SEL_WIDTH'(1);
        2'b01:   r_count <= r_count - SEL_WIDTH'(1);
        default: r_count <= r_count;
      endcase

      r_pending <= w_pending_nxt;

      if (w_pipe_win) begin
        r_write_en   <= 1'b1;
        r_write_sel  <= in_pipe_sel;
        r_write_data <= in_pipe_data;
      end else if (w_pop) begin
        // Entries targeting r0 are drained without asserting the write enable.
        r_write_en   <= (w_head_sel != '0);
        r_write_sel  <= w_head_sel;
        r_write_data <= w_head_data;
      end else begin
        r_write_en   <= 1'b0;
      end
    end
  end

  assign out_mc_ready   = w_ready;
  assign out_pending    = r_pending;
  assign out_fifo_count = r_count;
  assign out_write_en   = r_write_en;
  assign out_write_sel  = r_write_sel;
  assign out_write_data = r_write_data;

endmodule

// File: tb/tb_reg_file_writeback_arbiter.sv
// Purpose: self-checking bench for reg_file_writeback_arbiter against a queue-based reference model
// Latency: model predicts registered outputs one cycle after each driven input set
// Backpressure: model accepts multi-cycle offers only while its queue holds fewer than FIFO_DEPTH entries
module tb_reg_file_writeback_arbiter;

  localparam int DW = 32;
  localparam int NR = 16;
  localparam int SW = 4;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          pipe_valid;
  logic [SW-1:0] pipe_sel;
  logic [DW-1:0] pipe_data;
  logic          mc_valid;
  logic          mc_ready;
  logic [SW-1:0] mc_sel;
  logic [DW-1:0] mc_data;
  logic          claim_en;
  logic [SW-1:0] claim_sel;
  logic [NR-1:0] pending;
  logic [SW-1:0] fifo_count;
  logic          wr_en;
  logic [SW-1:0] wr_sel;
  logic [DW-1:0] wr_data;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [SW-1:0] q_sel [$];
  logic [DW-1:0] q_data [$];
  logic [NR-1:0] m_pending = '0;
  logic          m_en = 1'b0;
  logic [SW-1:0] m_sel = '0;
  logic [DW-1:0] m_data = '0;

  always #5 clk = ~clk;

  reg_file_writeback_arbiter #(
    .DATA_WIDTH(DW), .NUM_REGS(NR), .SEL_WIDTH(SW), .FIFO_DEPTH(FD)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .in_pipe_valid  (pipe_valid),
    .in_pipe_sel    (pipe_sel),
    .in_pipe_data   (pipe_data),
    .in_mc_valid    (mc_valid),
    .out_mc_ready   (mc_ready),
    .in_mc_sel      (mc_sel),
    .in_mc_data     (mc_data),
    .in_claim_en    (claim_en),
    .in_claim_sel   (claim_sel),
    .out_pending    (pending),
    .out_fifo_count (fifo_count),
    .out_write_en   (wr_en),
    .out_write_sel  (wr_sel),
    .out_write_data (wr_data)
  );

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    logic          can_push;
    logic          pipe_wins;
    logic [SW-1:0] hs;
    logic [DW-1:0] hd;
    if (rst) begin
      q_sel.delete();
      q_data.delete();
      m_pending = '0;
      m_en = 1'b0;
      m_sel = '0;
      m_data = '0;
      return;
    end
    can_push  = mc_valid && (q_sel.size() < FD);
    pipe_wins = pipe_valid && (pipe_sel != 0);
    if (pipe_wins) begin
      m_en = 1'b1;
      m_sel = pipe_sel;
      m_data = pipe_data;
    end else if (q_sel.size() > 0) begin
      hs = q_sel.pop_front();
      hd = q_data.pop_front();
      m_en = (hs != 0);
      m_sel = hs;
      m_data = hd;
      m_pending[hs] = 1'b0;
    end else begin
      m_en = 1'b0;
    end
    if (can_push) begin
      q_sel.push_back(mc_sel);
      q_data.push_back(mc_data);
    end
    if (claim_en && claim_sel != 0) m_pending[claim_sel] = 1'b1;
    m_pending[0] = 1'b0;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [57:0] dut_vec();
    return {wr_en, wr_sel, wr_data, pending, fifo_count, mc_ready};
  endfunction

  function automatic logic [57:0] model_vec();
    logic [SW-1:0] cnt;
    cnt = SW'(q_sel.size());
    return {m_en, m_sel, m_data, m_pending, cnt, (q_sel.size() < FD)};
  endfunction

  task automatic drive_idle();
    rst = 1'b0;
    pipe_valid = 1'b0; pipe_sel = '0; pipe_data = '0;
    mc_valid = 1'b0; mc_sel = '0; mc_data = '0;
    claim_en = 1'b0; claim_sel = '0;
  endtask

  task automatic do_reset();
    drive_idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({wr_en, wr_sel, wr_data} !== {1'b0, 4'd0, 32'd0}) begin
      n_errors++;
      $display("FAIL reset_write_port: got en=%0b sel=%0d data=%h want 0/0/0", wr_en, wr_sel, wr_data);
    end
    n_checks++;
    if ({pending, fifo_count, mc_ready} !== {16'h0, 4'd0, 1'b1}) begin
      n_errors++;
      $display("FAIL reset_state: got pending=%h count=%0d ready=%0b want 0/0/1", pending, fifo_count, mc_ready);
    end
  endtask

  task automatic test_pipe_write();
    do_reset();
    pipe_valid = 1'b1; pipe_sel = 4'd3; pipe_data = 32'hDEADBEEF;
    tick();
    n_checks++;
    if ({wr_en, wr_sel, wr_data} !== {1'b1, 4'd3, 32'hDEADBEEF}) begin
      n_errors++;
      $display("FAIL pipe_write: got en=%0b sel=%0d data=%h want 1/3/deadbeef", wr_en, wr_sel, wr_data);
    end
    drive_idle();
    tick();
    n_checks++;
    if ({wr_en, wr_sel, wr_data} !== {1'b0, 4'd3, 32'hDEADBEEF}) begin
      n_errors++;
      $display("FAIL pipe_idle_hold: got en=%0b sel=%0d data=%h want 0/3/deadbeef", wr_en, wr_sel, wr_data);
    end
  endtask

  task automatic test_mc_claim();
    do_reset();
    claim_en = 1'b1; claim_sel = 4'd5;
    tick();
    n_checks++;
    if (pending !== 16'h0020) begin
      n_errors++;
      $display("FAIL claim_sets_pending: got %h want 0020", pending);
    end
    drive_idle();
    mc_valid = 1'b1; mc_sel = 4'd5; mc_data = 32'h12345678;
    tick();
    n_checks++;
    if ({wr_en, fifo_count, pending} !== {1'b0, 4'd1, 16'h0020}) begin
      n_errors++;
      $display("FAIL mc_push: got en=%0b count=%0d pending=%h want 0/1/0020", wr_en, fifo_count, pending);
    end
    drive_idle();
    tick();
    n_checks++;
    if ({wr_en, wr_sel, wr_data, pending, fifo_count} !== {1'b1, 4'd5, 32'h12345678, 16'h0, 4'd0}) begin
      n_errors++;
      $display("FAIL mc_pop_write: got en=%0b sel=%0d data=%h pending=%h count=%0d want 1/5/12345678/0000/0",
               wr_en, wr_sel, wr_data, pending, fifo_count);
    end
  endtask

  task automatic test_fifo_full();
    do_reset();
    pipe_valid = 1'b1;
    mc_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      pipe_sel = SW'(9 + i); pipe_data = $urandom;
      mc_sel = SW'(i); mc_data = 32'h100 + i;
      tick();
      n_checks++;
      if (dut_vec() !== model_vec()) begin
        n_errors++;
        $display("FAIL fill_with_pipe[%0d]: got %h want %h", i, dut_vec(), model_vec());
      end
    end
    n_checks++;
    if ({fifo_count, mc_ready} !== {4'd4, 1'b0}) begin
      n_errors++;
      $display("FAIL fifo_full: got count=%0d ready=%0b want 4/0", fifo_count, mc_ready);
    end
    mc_sel = 4'd15; mc_data = 32'hBAD;
    pipe_sel = 4'd14;
    tick();
    n_checks++;
    if ({fifo_count, wr_sel} !== {4'd4, 4'd14}) begin
      n_errors++;
      $display("FAIL no_push_when_full: got count=%0d sel=%0d want 4/14", fifo_count, wr_sel);
    end
    drive_idle();
    for (int i = 1; i <= 4; i++) begin
      tick();
      n_checks++;
      if ({wr_en, wr_sel, wr_data} !== {1'b1, SW'(i), 32'h100 + i}) begin
        n_errors++;
        $display("FAIL drain_order[%0d]: got en=%0b sel=%0d data=%h want 1/%0d/%h",
                 i, wr_en, wr_sel, wr_data, i, 32'h100 + i);
      end
      if (i == 1) begin
        n_checks++;
        if (mc_ready !== 1'b1) begin
          n_errors++;
          $display("FAIL ready_after_pop: got %0b want 1", mc_ready);
        end
      end
    end
  endtask

  task automatic test_pipe_sel0();
    do_reset();
    pipe_valid = 1'b1; pipe_sel = 4'd5; pipe_data = 32'h1;
    mc_valid = 1'b1; mc_sel = 4'd7; mc_data = 32'hA5;
    tick();
    drive_idle();
    pipe_valid = 1'b1; pipe_sel = 4'd0; pipe_data = 32'hFFFF0000;
    tick();
    n_checks++;
    if ({wr_en, wr_sel, wr_data, fifo_count} !== {1'b1, 4'd7, 32'hA5, 4'd0}) begin
      n_errors++;
      $display("FAIL pipe_sel0_drain: got en=%0b sel=%0d data=%h count=%0d want 1/7/a5/0",
               wr_en, wr_sel, wr_data, fifo_count);
    end
  endtask

  task automatic test_fifo_sel0();
    do_reset();
    mc_valid = 1'b1; mc_sel = 4'd0; mc_data = 32'h55;
    tick();
    drive_idle();
    tick();
    n_checks++;
    if ({wr_en, fifo_count} !== {1'b0, 4'd0}) begin
      n_errors++;
      $display("FAIL fifo_sel0_pop: got en=%0b count=%0d want 0/0", wr_en, fifo_count);
    end
  endtask

  task automatic test_claim_pop();
    do_reset();
    claim_en = 1'b1; claim_sel = 4'd9;
    pipe_valid = 1'b1; pipe_sel = 4'd2; pipe_data = 32'h22;
    mc_valid = 1'b1; mc_sel = 4'd9; mc_data = 32'h99;
    tick();
    n_checks++;
    if ({pending, fifo_count} !== {16'h0200, 4'd1}) begin
      n_errors++;
      $display("FAIL claim9_setup: got pending=%h count=%0d want 0200/1", pending, fifo_count);
    end
    drive_idle();
    claim_en = 1'b1; claim_sel = 4'd9;
    tick();
    n_checks++;
    if ({wr_en, wr_sel, wr_data, pending} !== {1'b1, 4'd9, 32'h99, 16'h0200}) begin
      n_errors++;
      $display("FAIL set_wins_over_clear: got en=%0b sel=%0d data=%h pending=%h want 1/9/99/0200",
               wr_en, wr_sel, wr_data, pending);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    pipe_valid = 1'b1; pipe_sel = 4'd1;
    mc_valid = 1'b1; claim_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mc_sel = SW'(3 + 3 * i); claim_sel = SW'(3 + 3 * i); mc_data = $urandom;
      tick();
    end
    n_checks++;
    if ({fifo_count, pending} !== {4'd3, 16'h0248}) begin
      n_errors++;
      $display("FAIL mid_setup: got count=%0d pending=%h want 3/0248", fifo_count, pending);
    end
    drive_idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if ({fifo_count, pending, wr_en, mc_ready} !== {4'd0, 16'h0, 1'b0, 1'b1}) begin
      n_errors++;
      $display("FAIL mid_reset: got count=%0d pending=%h en=%0b ready=%0b want 0/0/0/1",
               fifo_count, pending, wr_en, mc_ready);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (wr_en !== 1'b0) begin
        n_errors++;
        $display("FAIL dropped_entry_written[%0d]: got en=%0b sel=%0d want en=0", i, wr_en, wr_sel);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 500; c++) begin
      rst        = ($urandom_range(0, 99) == 0);
      pipe_valid = ($urandom_range(0, 2) == 0);
      pipe_sel   = SW'($urandom_range(0, 15));
      pipe_data  = $urandom;
      mc_valid   = ($urandom_range(0, 1) == 0);
      mc_sel     = SW'($urandom_range(0, 15));
      mc_data    = $urandom;
      claim_en   = ($urandom_range(0, 2) == 0);
      claim_sel  = SW'($urandom_range(0, 15));
      tick();
      n_checks++;
      if (dut_vec() !== model_vec()) begin
        n_errors++;
        $display("FAIL random[%0d]: got %h want %h (en,sel,data,pending,count,ready)", c, dut_vec(), model_vec());
      end
    end
    drive_idle();
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_pipe_write();
    test_mc_claim();
    test_fifo_full();
    test_pipe_sel0();
    test_fifo_sel0();
    test_claim_pop();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
